// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges never-stalled ALU results with handshaked load results
// onto the single register-file write port, with an in-order load FIFO and WAW squash.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [63:0]              alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [63:0]              ld_data,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [63:0]              WriteData,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [63:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] sq_q, sq_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             regwrite_q, regwrite_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [63:0]      wdata_q, wdata_d;

  logic ld_acc, ld_keep, alu_wr, fifo_empty, push, pop;
  logic hit1_fifo, hit2_fifo;

  assign ld_ready   = (count_q < CW'(DEPTH));
  assign ld_acc     = ld_valid && ld_ready;
  // x31 loads are consumed by the handshake but never stored
  assign ld_keep    = ld_acc && (ld_rd != 5'd31);
  assign alu_wr     = alu_valid && (alu_rd != 5'd31);
  assign fifo_empty = (count_q == '0);

  always_comb begin
    rd_d       = rd_q;
    data_d     = data_q;
    vld_d      = vld_q;
    sq_d       = sq_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (alu_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (rd_q[i] == alu_rd)) sq_d[i] = 1'b1;
      end
    end

    // An x31 ALU result still owns the port this cycle, so loads must queue
    if (alu_valid) begin
      regwrite_d = alu_wr;
      if (alu_wr) begin
        wreg_d  = alu_rd;
        wdata_d = alu_data;
      end
      push = ld_keep;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      regwrite_d = !sq_q[rptr_q];
      if (!sq_q[rptr_q]) begin
        wreg_d  = rd_q[rptr_q];
        wdata_d = data_q[rptr_q];
      end
      push = ld_keep;
    end else if (ld_keep) begin
      regwrite_d = 1'b1;
      wreg_d     = ld_rd;
      wdata_d    = ld_data;
    end

    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      sq_d[rptr_q]  = 1'b0;
      rptr_d        = rptr_q + PW'(1);
    end

    // Push slot never equals the pop slot: push requires a free entry
    if (push) begin
      vld_d[wptr_q]  = 1'b1;
      sq_d[wptr_q]   = alu_wr && (ld_rd == alu_rd);
      rd_d[wptr_q]   = ld_rd;
      data_d[wptr_q] = ld_data;
      wptr_d         = wptr_q + PW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      vld_q      <= '0;
      sq_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_q       <= rd_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      sq_q       <= sq_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    hit1_fifo = 1'b0;
    hit2_fifo = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !sq_q[i] && (rd_q[i] == q_rs1)) hit1_fifo = 1'b1;
      if (vld_q[i] && !sq_q[i] && (rd_q[i] == q_rs2)) hit2_fifo = 1'b1;
    end
  end

  assign q_hit1 = (q_rs1 != 5'd31) &&
                  (hit1_fifo || (regwrite_q && (wreg_q == q_rs1)));
  assign q_hit2 = (q_rs2 != 5'd31) &&
                  (hit2_fifo || (regwrite_q && (wreg_q == q_rs2)));

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: bypass, ALU priority, back-pressure,
// WAW squash, x31 handling, hazard query and asynchronous reset.
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_hit1;
  logic        q_hit2;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .q_hit1       (q_hit1),
    .q_hit2       (q_hit2),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [63:0] d);
    ld_valid = 1'b1; ld_rd = rd; ld_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [63:0] d);
    chk({tag, ".we"},   64'(RegWrite), 64'd1);
    chk({tag, ".reg"},  64'(WriteRegister), 64'(rd));
    chk({tag, ".data"}, WriteData, d);
  endtask

  initial begin
    reset = 1'b0; q_rs1 = '0; q_rs2 = '0;
    idle();

    // Reset state
    tick(); tick();
    chk("rst.we",    64'(RegWrite), 64'd0);
    chk("rst.reg",   64'(WriteRegister), 64'd0);
    chk("rst.data",  WriteData, 64'd0);
    chk("rst.count", 64'(fifo_count), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst.ready", 64'(ld_ready), 64'd1);

    // Bypass of a lone load
    ld(5'd5, 64'hAA);
    tick(); idle();
    chk_wr("byp", 5'd5, 64'hAA);
    chk("byp.count", 64'(fifo_count), 64'd0);
    tick();
    chk("byp.idle_we",  64'(RegWrite), 64'd0);
    chk("byp.hold_reg", 64'(WriteRegister), 64'd5);

    // ALU priority with loads queueing behind it
    alu(5'd2, 64'h11); ld(5'd7, 64'h70);
    tick();
    chk_wr("pri.a0", 5'd2, 64'h11);
    chk("pri.c1", 64'(fifo_count), 64'd1);
    alu(5'd2, 64'h11); ld(5'd8, 64'h80);
    tick();
    chk_wr("pri.a1", 5'd2, 64'h11);
    chk("pri.c2", 64'(fifo_count), 64'd2);
    alu(5'd2, 64'h11); ld(5'd9, 64'h90);
    tick(); idle();
    chk_wr("pri.a2", 5'd2, 64'h11);
    chk("pri.c3", 64'(fifo_count), 64'd3);
    tick();
    chk_wr("pri.l7", 5'd7, 64'h70);
    chk("pri.c2b", 64'(fifo_count), 64'd2);
    tick();
    chk_wr("pri.l8", 5'd8, 64'h80);
    tick();
    chk_wr("pri.l9", 5'd9, 64'h90);
    chk("pri.c0", 64'(fifo_count), 64'd0);
    tick();
    chk("pri.idle", 64'(RegWrite), 64'd0);

    // Full back-pressure: loads 10..15 while ALU holds the port
    alu(5'd1, 64'h1); ld(5'd10, 64'h110);
    tick(); ld(5'd11, 64'h111);
    tick(); ld(5'd12, 64'h112);
    tick(); ld(5'd13, 64'h113);
    tick();
    chk("full.count", 64'(fifo_count), 64'd4);
    chk("full.ready", 64'(ld_ready), 64'd0);
    ld(5'd14, 64'h114);
    tick();
    chk_wr("full.alu", 5'd1, 64'h1);
    chk("full.count_held", 64'(fifo_count), 64'd4);
    chk("full.ready_held", 64'(ld_ready), 64'd0);
    alu_valid = 1'b0;
    tick();
    chk_wr("full.p10", 5'd10, 64'h110);
    chk("full.c3", 64'(fifo_count), 64'd3);
    chk("full.ready_back", 64'(ld_ready), 64'd1);
    tick(); ld(5'd15, 64'h115);
    chk_wr("full.p11", 5'd11, 64'h111);
    chk("full.c3b", 64'(fifo_count), 64'd3);
    tick(); idle();
    chk_wr("full.p12", 5'd12, 64'h112);
    chk("full.c3c", 64'(fifo_count), 64'd3);
    tick();
    chk_wr("full.p13", 5'd13, 64'h113);
    tick();
    chk_wr("full.p14", 5'd14, 64'h114);
    tick();
    chk_wr("full.p15", 5'd15, 64'h115);
    chk("full.c0", 64'(fifo_count), 64'd0);
    tick();
    chk("full.no_dup", 64'(RegWrite), 64'd0);

    // WAW squash of a queued load
    alu(5'd1, 64'h1); ld(5'd3, 64'h33);
    tick(); idle();
    chk("waw.c1", 64'(fifo_count), 64'd1);
    alu(5'd3, 64'h44);
    tick(); idle();
    chk_wr("waw.alu", 5'd3, 64'h44);
    chk("waw.slot_kept", 64'(fifo_count), 64'd1);
    q_rs1 = 5'd3;
    tick();
    chk("waw.sq_we",   64'(RegWrite), 64'd0);
    chk("waw.sq_data", WriteData, 64'h44);
    chk("waw.c0",      64'(fifo_count), 64'd0);
    chk("waw.nohit",   64'(q_hit1), 64'd0);

    // Same-cycle load and ALU to the same register
    alu(5'd4, 64'h55); ld(5'd4, 64'h66);
    tick(); idle();
    chk_wr("waw2.alu", 5'd4, 64'h55);
    chk("waw2.c1", 64'(fifo_count), 64'd1);
    tick();
    chk("waw2.sq_we",   64'(RegWrite), 64'd0);
    chk("waw2.sq_data", WriteData, 64'h55);

    // x31 handling
    q_rs1 = 5'd31;
    alu(5'd31, 64'h77); ld(5'd31, 64'h88);
    tick(); idle();
    chk("x31.we",    64'(RegWrite), 64'd0);
    chk("x31.count", 64'(fifo_count), 64'd0);
    chk("x31.hit",   64'(q_hit1), 64'd0);
    alu(5'd31, 64'h77); ld(5'd6, 64'h60);
    tick(); idle();
    chk("x31.alu_blocks_we", 64'(RegWrite), 64'd0);
    chk("x31.alu_blocks_c",  64'(fifo_count), 64'd1);
    tick();
    chk_wr("x31.l6", 5'd6, 64'h60);

    // Hazard query follows a load through FIFO and output stage
    alu(5'd1, 64'h1); ld(5'd12, 64'hC0);
    q_rs1 = 5'd13; q_rs2 = 5'd12;
    tick(); idle();
    chk("q.fifo_hit", 64'(q_hit2), 64'd1);
    chk("q.miss",     64'(q_hit1), 64'd0);
    tick();
    chk_wr("q.l12", 5'd12, 64'hC0);
    chk("q.out_hit", 64'(q_hit2), 64'd1);
    tick();
    chk("q.dropped", 64'(q_hit2), 64'd0);

    // Asynchronous reset with entries queued and a write on the port
    alu(5'd1, 64'h1); ld(5'd20, 64'h200);
    tick(); ld(5'd21, 64'h201);
    tick(); ld(5'd22, 64'h202);
    tick();
    chk("mrst.pre_c",  64'(fifo_count), 64'd3);
    chk("mrst.pre_we", 64'(RegWrite), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mrst.we",    64'(RegWrite), 64'd0);
    chk("mrst.reg",   64'(WriteRegister), 64'd0);
    chk("mrst.data",  WriteData, 64'd0);
    chk("mrst.count", 64'(fifo_count), 64'd0);
    idle();
    tick();
    reset = 1'b1;
    tick();
    chk("mrst.post_we", 64'(RegWrite), 64'd0);
    chk("mrst.post_c",  64'(fifo_count), 64'd0);
    tick();
    chk("mrst.post_we2", 64'(RegWrite), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-stage arbiter that feeds the register file's single write port (WriteData / WriteRegister / RegWrite).
- Merges two producers:
  - ALU results: always accepted, highest priority.
  - Load results: valid/ready handshake, buffered in an in-order FIFO while the port is busy.
- Resolves write-after-write ordering between a queued load and a newer ALU write.
- Exposes pending-write query ports for the decode-stage hazard logic.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result present this cycle; never back-pressured
- alu_rd  input  5  ALU destination register
- alu_data  input  64  ALU result
- ld_valid  input  1  load result offered
- ld_ready  output  1  arbiter can accept a load this cycle
- ld_rd  input  5  load destination register
- ld_data  input  64  load data
- RegWrite  output  1  registered write enable to the regfile
- WriteRegister  output  5  registered write address
- WriteData  output  64  registered write data
- q_rs1  input  5  query register 1
- q_rs2  input  5  query register 2
- q_hit1  output  1  write to q_rs1 pending (combinational)
- q_hit2  output  1  write to q_rs2 pending (combinational)
- fifo_count  output  $clog2(DEPTH)+1  live FIFO occupancy, squashed entries included

Behaviour:
- Reset (reset=0, asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FIFO empty; fifo_count=0; all entry valid/squash bits cleared.
  - ld_ready=1 once reset is released.
  - Reset mid-operation discards every queued and in-flight write; no partial write is emitted.
- Handshake:
  - ld_ready = (fifo_count < DEPTH), derived only from registered state.
  - A load is accepted iff ld_valid && ld_ready.
  - ld_valid with ld_ready=0 leaves the load with the producer; it must hold ld_rd/ld_data stable.
- X31 rule:
  - An accepted load with ld_rd==31 is consumed and discarded: not enqueued, no write.
  - An ALU result with alu_rd==31 produces no write but still counts as an ALU cycle for arbitration.
- Output stage: one write per cycle, registered, latency 1. Priority at each rising edge:
  1. alu_valid (and alu_rd!=31): output {1, alu_rd, alu_data}. Any accepted load is pushed into the FIFO.
  2. FIFO non-empty: pop head. Unsquashed head → output {1, rd, data}; squashed head → RegWrite=0. An accepted load is pushed in the same cycle (simultaneous push/pop).
  3. FIFO empty and load accepted: bypass straight to the output, 1-cycle latency; nothing enqueued.
  4. Otherwise RegWrite=0. WriteRegister/WriteData hold their previous values.
- Ordering:
  - Loads leave in acceptance order.
  - A load accepted in the same cycle as alu_valid is older than that ALU result.
- WAW squash:
  - When alu_valid with alu_rd!=31, every valid FIFO entry with rd==alu_rd gets its squash bit set at that edge.
  - A load accepted in that same cycle with ld_rd==alu_rd is enqueued already squashed.
  - Squashed entries still occupy a slot and cost one pop cycle.
- Full/wrap:
  - FIFO uses wrap-around read/write pointers.
  - When full, pop frees one slot; ld_ready rises the following cycle, not combinationally.
  - fifo_count never exceeds DEPTH.
- Query (combinational):
  - q_hitN = (q_rsN!=31) && ( (RegWrite && WriteRegister==q_rsN) || some valid, unsquashed FIFO entry has rd==q_rsN ).
  - Current-cycle inputs are not searched.

Test Plan:
- Reset and bypass: reset low for 2 cycles → RegWrite=0, fifo_count=0, ld_ready=1. Then ld_valid, ld_rd=5, ld_data=0xAA alone → next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA; fifo_count stays 0.
- ALU priority plus queueing: alu_valid (rd=2, 0x11) for 3 cycles while loads (rd=7,8,9) are offered → three ALU writes first, then 7, 8, 9 in order; fifo_count peaks at 3.
- Full back-pressure:
  - Hold alu_valid, offer 6 loads → ld_ready=0 once fifo_count=4; loads 5–6 are held by the producer.
  - Drop alu_valid → four pops in order; ld_ready returns 1 the cycle after the first pop.
  - Exactly 6 load writes in total, none lost or duplicated.
- WAW squash:
  - Queue load rd=3 (0x33); then alu_valid rd=3 (0x44) → write 0x44 to X3; the squashed slot emits RegWrite=0 and X3 is never rewritten with 0x33.
  - Same-cycle load rd=4 plus alu rd=4 → only the ALU value is written.
- X31 and query:
  - Load rd=31 and ALU rd=31 → no RegWrite pulse; q_hit1 with q_rs1=31 stays 0.
  - With load rd=12 queued, q_rs2=12 → q_hit2=1; it drops the cycle after the write for rd=12 leaves the output stage.
- Mid-operation reset: assert reset with 3 entries queued and RegWrite=1 → all outputs 0 immediately (asynchronous), fifo_count=0, and nothing is emitted after release.
